// File: rtl/hy_cnt_arb_if.sv
// Bus bundle between timer clients and the shared count scheduler.
// The master side (clients/bench) drives requests and delay values; the
// slave side (scheduler) returns grant, completion and counter status.
interface hy_cnt_arb_if #(
  parameter int N_REQ   = 4,
  parameter int C_WIDTH = 32,
  parameter int ID_W    = 2
) ();

  logic [N_REQ-1:0]         req;
  logic [N_REQ*C_WIDTH-1:0] load_val;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         done;
  logic                     busy;
  logic [ID_W-1:0]          cur_id;
  logic [C_WIDTH-1:0]       cnt_out;

  modport master (
    output req,
    output load_val,
    input  gnt,
    input  done,
    input  busy,
    input  cur_id,
    input  cnt_out
  );

  modport slave (
    input  req,
    input  load_val,
    output gnt,
    output done,
    output busy,
    output cur_id,
    output cnt_out
  );

endinterface

// File: rtl/hy_cnt_arb.sv
// Round-robin scheduler sharing one reloadable down counter among N_REQ
// requesters. The owner's delay is loaded at the grant edge, counted down
// to zero, and a one-cycle done pulse returns to the owner.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | counter free; arbitrate among set req bits starting at ptr
// COUNT | counter owned by cur_id; decrement until zero or owner aborts
// DONE  | done pulse is visible this cycle; no arbitration
module hy_cnt_arb #(
  parameter int C_WIDTH = 32,
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hy_cnt_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [C_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        scan_idx;
  logic [ID_W-1:0]    scan_id;
  logic [N_REQ-1:0]   win_onehot;
  logic [N_REQ-1:0]   owner_onehot;
  logic [C_WIDTH-1:0] win_load;
  logic               owner_req;
  logic [ID_W-1:0]    id_next;

  // Round-robin pick: first set req bit scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    scan_id   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = (32'(ptr_q) + 32'(i)) % 32'(N_REQ);
      scan_id  = scan_idx[ID_W-1:0];
      if (!win_found && bus.req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // One-hot decodes, winner's delay value and the owner's successor index.
  always_comb begin
    win_onehot           = '0;
    win_onehot[win_id]   = 1'b1;
    owner_onehot         = '0;
    owner_onehot[id_q]   = 1'b1;
    win_load             = bus.load_val[32'(win_id)*C_WIDTH +: C_WIDTH];
    owner_req            = bus.req[id_q];
    id_next              = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          cnt_d   = win_load;
          gnt_d   = win_onehot;
          id_d    = win_id;
          busy_d  = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Abort takes priority over reaching zero; the count is frozen.
        if (!owner_req) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = id_next;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          done_d  = owner_onehot;
          gnt_d   = '0;
          ptr_d   = id_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - C_WIDTH'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.cur_id  = id_q;
  assign bus.cnt_out = cnt_q;

endmodule

// File: tb/tb_hy_cnt_arb.sv
// Bench for hy_cnt_arb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_hy_cnt_arb;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  hy_cnt_arb_if #(.N_REQ(N), .C_WIDTH(CW), .ID_W(IW)) bus ();

  hy_cnt_arb #(.C_WIDTH(CW), .N_REQ(N), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state: who owns the counter, how much is left, whether a done
  // pulse is currently being shown, and where the next scan starts
  int          m_owner;
  bit          m_finishing;
  int          m_ptr;
  logic [N-1:0]  m_gnt;
  logic [N-1:0]  m_done;
  logic          m_busy;
  logic [IW-1:0] m_id;
  logic [CW-1:0] m_cnt;
  int            m_j;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: reacts to requests sampled at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_finishing = 0; m_ptr = 0;
      m_gnt = '0; m_done = '0; m_busy = 0; m_id = '0; m_cnt = '0;
    end else begin
      m_done = '0;
      if (m_finishing) begin
        m_finishing = 0;
        m_busy = 0;
      end else if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          m_j = (m_ptr + k) % N;
          if (bus.req[m_j]) begin
            m_owner = m_j;
            m_gnt   = '0;
            m_gnt[m_j] = 1'b1;
            m_id    = IW'(m_j);
            m_cnt   = bus.load_val[m_j*CW +: CW];
            m_busy  = 1;
            break;
          end
        end
      end else if (!bus.req[m_owner]) begin
        m_gnt = '0; m_busy = 0;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_cnt == 0) begin
        m_done[m_owner] = 1'b1;
        m_gnt = '0;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_finishing = 1;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    check("gnt",     64'(bus.gnt),     64'(m_gnt));
    check("done",    64'(bus.done),    64'(m_done));
    check("busy",    64'(bus.busy),    64'(m_busy));
    check("cur_id",  64'(bus.cur_id),  64'(m_id));
    check("cnt_out", 64'(bus.cnt_out), 64'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_load(input int i, input logic [CW-1:0] v);
    bus.load_val[i*CW +: CW] = v;
  endtask

  function automatic int onehot_id(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  int           gnt_ids[$];
  int           gnt_cyc[$];
  logic [N-1:0] prev_gnt;
  logic [N-1:0] done_seen;
  bit           found;

  initial begin
    bus.req = '0;
    bus.load_val = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt",  64'(bus.gnt),     64'h0);
    check("rst_done", 64'(bus.done),    64'h0);
    check("rst_busy", 64'(bus.busy),    64'h0);
    check("rst_cnt",  64'(bus.cnt_out), 64'h0);
    check("rst_id",   64'(bus.cur_id),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request, L = 3
    do_reset();
    bus.req = 4'b0010; set_load(1, 3);
    step();
    check("single_gnt", 64'(bus.gnt), 64'h2);
    check("single_cnt_l", 64'(bus.cnt_out), 64'd3);
    step(); check("single_cnt2", 64'(bus.cnt_out), 64'd2);
    step(); check("single_cnt1", 64'(bus.cnt_out), 64'd1);
    step(); check("single_cnt0", 64'(bus.cnt_out), 64'd0);
    check("single_nodone_e3", 64'(bus.done), 64'h0);
    step();
    check("single_done_e4", 64'(bus.done), 64'h2);
    check("single_gnt_e4", 64'(bus.gnt), 64'h0);
    check("single_busy_e4", 64'(bus.busy), 64'h1);
    bus.req = '0;
    step();
    check("single_done_e5", 64'(bus.done), 64'h0);
    check("single_busy_e5", 64'(bus.busy), 64'h0);

    // zero length
    bus.req = 4'b0100; set_load(2, 0);
    step();
    check("zero_gnt", 64'(bus.gnt), 64'h4);
    check("zero_cnt", 64'(bus.cnt_out), 64'd0);
    step();
    check("zero_done", 64'(bus.done), 64'h4);
    check("zero_cnt_e1", 64'(bus.cnt_out), 64'd0);
    bus.req = '0;
    step();
    check("zero_busy", 64'(bus.busy), 64'h0);

    // full contention, L = 1 each, requesters re-assert after done
    do_reset();
    for (int i = 0; i < N; i++) set_load(i, 1);
    bus.req = 4'b1111;
    gnt_ids.delete(); gnt_cyc.delete(); prev_gnt = '0;
    for (int t = 0; t < 22; t++) begin
      step();
      if (bus.gnt != '0 && prev_gnt == '0) begin
        gnt_ids.push_back(onehot_id(bus.gnt));
        gnt_cyc.push_back(cyc);
      end
      prev_gnt = bus.gnt;
      bus.req = 4'b1111 & ~m_done;
    end
    check("cont_ngrants", 64'(gnt_ids.size() >= 5), 64'h1);
    if (gnt_ids.size() >= 5) begin
      check("cont_g0", 64'(gnt_ids[0]), 64'd0);
      check("cont_g1", 64'(gnt_ids[1]), 64'd1);
      check("cont_g2", 64'(gnt_ids[2]), 64'd2);
      check("cont_g3", 64'(gnt_ids[3]), 64'd3);
      check("cont_g4", 64'(gnt_ids[4]), 64'd0);
      for (int k = 1; k < 5; k++)
        check("cont_period", 64'(gnt_cyc[k] - gnt_cyc[k-1]), 64'd4);
    end

    // fairness: req[0] and req[2] held high, L = 5
    do_reset();
    for (int i = 0; i < N; i++) set_load(i, 5);
    bus.req = 4'b0101;
    gnt_ids.delete(); prev_gnt = '0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (bus.gnt != '0 && prev_gnt == '0) gnt_ids.push_back(onehot_id(bus.gnt));
      prev_gnt = bus.gnt;
    end
    check("fair_ngrants", 64'(gnt_ids.size() >= 4), 64'h1);
    if (gnt_ids.size() >= 4) begin
      check("fair_g0", 64'(gnt_ids[0]), 64'd0);
      check("fair_g1", 64'(gnt_ids[1]), 64'd2);
      check("fair_g2", 64'(gnt_ids[2]), 64'd0);
      check("fair_g3", 64'(gnt_ids[3]), 64'd2);
    end
    foreach (gnt_ids[k]) check("fair_never1", 64'(gnt_ids[k] == 1), 64'h0);

    // abort: req[3] with L = 10, dropped at cnt_out = 6, req[0] pending
    do_reset();
    set_load(3, 10); set_load(0, 2);
    bus.req = 4'b1000;
    step();
    check("abort_gnt", 64'(bus.gnt), 64'h8);
    check("abort_cnt_l", 64'(bus.cnt_out), 64'd10);
    bus.req[0] = 1'b1;
    done_seen = '0; found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (bus.cnt_out == 6) found = 1;
      else begin step(); done_seen |= bus.done; end
    end
    check("abort_reach6", 64'(found), 64'h1);
    bus.req[3] = 1'b0;
    step();
    done_seen |= bus.done;
    check("abort_gnt0", 64'(bus.gnt), 64'h0);
    check("abort_busy0", 64'(bus.busy), 64'h0);
    check("abort_cnt_hold", 64'(bus.cnt_out), 64'd6);
    step();
    done_seen |= bus.done;
    check("abort_next_gnt", 64'(bus.gnt), 64'h1);
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      step();
      done_seen |= bus.done;
      if (bus.done[0]) begin found = 1; bus.req = '0; end
    end
    check("abort_req0_done", 64'(found), 64'h1);
    check("abort_no_done3", 64'(done_seen[3]), 64'h0);
    step();

    // async reset mid-count
    do_reset();
    set_load(2, 20);
    bus.req = 4'b0100;
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      step();
      if (bus.cnt_out == 7 && bus.busy) found = 1;
    end
    check("arst_reach7", 64'(found), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt",  64'(bus.gnt),     64'h0);
    check("arst_done", 64'(bus.done),    64'h0);
    check("arst_busy", 64'(bus.busy),    64'h0);
    check("arst_cnt",  64'(bus.cnt_out), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_regrant", 64'(bus.gnt), 64'h4);
    check("arst_cnt_l", 64'(bus.cnt_out), 64'd20);
    bus.req = '0;
    step();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) set_load(i, CW'($urandom_range(0, 6)));
    for (int t = 0; t < 1500; t++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (m_done[i]) bus.req[i] = 1'b0;
        else if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
        if ($urandom_range(0, 15) == 0) set_load(i, CW'($urandom_range(0, 6)));
      end
      if (t == 733) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    bus.req = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
